// File: rtl/btn_pkg.sv
// Shared types and counter-width helpers for the button conditioner.
// Width constants below describe the default configuration; modules derive their own via cnt_width().
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } btn_state_t;

   // Bits needed to hold values 0..max_cnt-1, never less than one bit.
   function automatic int cnt_width(input int max_cnt);
      return (max_cnt <= 2) ? 1 : $clog2(max_cnt);
   endfunction

   localparam int DEF_STABLE_CNT = 4;
   localparam int DEF_HOLD_CNT   = 8;
   localparam int DEF_REPEAT_CNT = 3;

   localparam int CNT_W  = cnt_width(DEF_STABLE_CNT);
   localparam int HCNT_W = cnt_width((DEF_HOLD_CNT > DEF_REPEAT_CNT) ? DEF_HOLD_CNT : DEF_REPEAT_CNT);

endpackage

// File: rtl/btn_debounce_array_if.sv
// Front-panel button bus: raw inputs plus tick strobe in, conditioned levels and event pulses out.
// The master drives buttons and tick; the slave (conditioner) drives the results.
interface btn_debounce_array_if #(
   parameter int N_BTN = 4
);
   logic             tick_en;
   logic [N_BTN-1:0] btn_in;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;
   logic [N_BTN-1:0] btn_hold;
   logic [N_BTN-1:0] btn_repeat;
   logic             any_press;

   modport master (
      output tick_en, btn_in,
      input  btn_level, btn_press, btn_release, btn_hold, btn_repeat, any_press
   );

   modport slave (
      input  tick_en, btn_in,
      output btn_level, btn_press, btn_release, btn_hold, btn_repeat, any_press
   );
endinterface

// File: rtl/btn_chan.sv
// One button channel: synchroniser, tick-sampled stability filter, press/hold/repeat FSM.
// Level change lands SYNC_STAGES clk + STABLE_CNT ticks after a clean edge; no backpressure, pulses are fire-and-forget.
module btn_chan
   import btn_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int STABLE_CNT  = 4,
   parameter int HOLD_CNT    = 8,
   parameter int REPEAT_CNT  = 3,
   parameter int REPEAT_EN   = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_en,
   input  logic din,
   output logic level,
   output logic press,
   output logic rel,
   output logic hold,
   output logic rpt,
   output logic press_nxt
);

   localparam int HMAX = (HOLD_CNT > REPEAT_CNT) ? HOLD_CNT : REPEAT_CNT;
   localparam int CW   = cnt_width(STABLE_CNT);
   localparam int HW   = cnt_width(HMAX);

   localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CNT - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CNT - 1);
   localparam logic [HW-1:0] RPT_LAST  = HW'(REPEAT_CNT - 1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   sync_q;
   logic [CW-1:0]          cnt;
   logic [HW-1:0]          hcnt;
   btn_state_t             state;
   logic                   accept;
   logic                   acc_rise;
   logic                   acc_fall;

   assign sync_q    = sync_r[SYNC_STAGES-1];
   assign accept    = tick_en && (sync_q != level) && (cnt == CNT_LAST);
   assign acc_rise  = accept && sync_q;
   assign acc_fall  = accept && !sync_q;
   assign press_nxt = acc_rise;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      end
   end

   // Any sample that agrees with the current level restarts the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
         rel   <= 1'b0;
      end else begin
         press <= acc_rise;
         rel   <= acc_fall;
         if (tick_en) begin
            if (sync_q != level) begin
               if (cnt == CNT_LAST) begin
                  level <= sync_q;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end else begin
               cnt <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         hcnt  <= '0;
         hold  <= 1'b0;
         rpt   <= 1'b0;
      end else begin
         rpt <= 1'b0;
         if (tick_en) begin
            case (state)
               IDLE: begin
                  if (acc_rise) begin
                     state <= PRESSED;
                     hcnt  <= '0;
                  end
               end
               PRESSED: begin
                  if (acc_fall) begin
                     state <= IDLE;
                  end else if (hcnt == HOLD_LAST) begin
                     state <= HELD;
                     hold  <= 1'b1;
                     rpt   <= 1'b1;
                     hcnt  <= '0;
                  end else begin
                     hcnt <= hcnt + 1'b1;
                  end
               end
               HELD: begin
                  // A release on the same tick suppresses any repeat pulse.
                  if (acc_fall) begin
                     state <= IDLE;
                     hold  <= 1'b0;
                  end else if (REPEAT_EN != 0) begin
                     if (hcnt == RPT_LAST) begin
                        rpt  <= 1'b1;
                        hcnt <= '0;
                     end else begin
                        hcnt <= hcnt + 1'b1;
                     end
                  end else if (hcnt != RPT_LAST) begin
                     hcnt <= hcnt + 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  hold  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/btn_debounce_array.sv
// N-channel front-panel button conditioner: replicates btn_chan and ORs the press events.
// any_press is registered alongside the per-channel press pulses; outputs are pulses, no backpressure.
module btn_debounce_array
   import btn_pkg::*;
#(
   parameter int N_BTN       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int STABLE_CNT  = 4,
   parameter int HOLD_CNT    = 8,
   parameter int REPEAT_CNT  = 3,
   parameter int REPEAT_EN   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   btn_debounce_array_if.slave  bus
);

   logic [N_BTN-1:0] level_v;
   logic [N_BTN-1:0] press_v;
   logic [N_BTN-1:0] rel_v;
   logic [N_BTN-1:0] hold_v;
   logic [N_BTN-1:0] rpt_v;
   logic [N_BTN-1:0] press_nxt_v;
   logic             any_q;

   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      btn_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .STABLE_CNT  (STABLE_CNT),
         .HOLD_CNT    (HOLD_CNT),
         .REPEAT_CNT  (REPEAT_CNT),
         .REPEAT_EN   (REPEAT_EN)
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .tick_en   (bus.tick_en),
         .din       (bus.btn_in[i]),
         .level     (level_v[i]),
         .press     (press_v[i]),
         .rel       (rel_v[i]),
         .hold      (hold_v[i]),
         .rpt       (rpt_v[i]),
         .press_nxt (press_nxt_v[i])
      );
   end

   // Registered from the next-state press terms so it lines up with btn_press.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         any_q <= 1'b0;
      end else begin
         any_q <= |press_nxt_v;
      end
   end

   assign bus.btn_level   = level_v;
   assign bus.btn_press   = press_v;
   assign bus.btn_release = rel_v;
   assign bus.btn_hold    = hold_v;
   assign bus.btn_repeat  = rpt_v;
   assign bus.any_press   = any_q;

endmodule

// File: tb/tb_btn_debounce_array.sv
// Directed bench for btn_debounce_array: two instances (repeat enabled / disabled) share one stimulus.
module tb_btn_debounce_array;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick_en = 1'b0;
   logic [3:0] btn_in = 4'h0;
   int         n_checks = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   btn_debounce_array_if #(.N_BTN(4)) bi0 ();
   btn_debounce_array_if #(.N_BTN(4)) bi1 ();

   assign bi0.tick_en = tick_en;
   assign bi0.btn_in  = btn_in;
   assign bi1.tick_en = tick_en;
   assign bi1.btn_in  = btn_in;

   btn_debounce_array #(.N_BTN(4), .REPEAT_EN(1)) u_dut0 (.clk(clk), .rst(rst), .bus(bi0));
   btn_debounce_array #(.N_BTN(4), .REPEAT_EN(0)) u_dut1 (.clk(clk), .rst(rst), .bus(bi1));

   // Entered and left on a negedge; drives v, then one tick cycle 3 clk later (4 clk per call).
   task automatic step_tick(input logic [3:0] v);
      btn_in = v;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      tick_en = 1'b1;
      @(negedge clk);
      tick_en = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b0;
      tick_en = 1'b0;
      btn_in  = 4'h0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      logic [3:0] exp4;
      @(negedge clk);
      btn_in = 4'hF;
      rst    = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bi0.btn_level, bi0.btn_press, bi0.btn_release, bi0.btn_hold, bi0.btn_repeat, bi0.any_press} !== 21'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got lvl=%h prs=%h rel=%h hld=%h rpt=%h any=%b required all 0",
                  bi0.btn_level, bi0.btn_press, bi0.btn_release, bi0.btn_hold, bi0.btn_repeat, bi0.any_press);
      end
      n_checks++;
      if (bi1.btn_level !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_level_dut1: got %h required 0", bi1.btn_level);
      end
      rst = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step_tick(4'hF);
         exp4 = (i == 4) ? 4'hF : 4'h0;
         n_checks++;
         if (bi0.btn_level !== exp4) begin
            n_fail++;
            $display("FAIL reset_release_level tick %0d: got %h required %h", i, bi0.btn_level, exp4);
         end
         n_checks++;
         if (bi0.btn_press !== exp4) begin
            n_fail++;
            $display("FAIL reset_release_press tick %0d: got %h required %h", i, bi0.btn_press, exp4);
         end
         n_checks++;
         if (bi0.any_press !== (i == 4)) begin
            n_fail++;
            $display("FAIL reset_release_any tick %0d: got %b required %b", i, bi0.any_press, (i == 4));
         end
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (bi0.any_press !== 1'b0 || bi0.btn_press !== 4'h0) begin
         n_fail++;
         $display("FAIL press_one_cycle: got any=%b press=%h required 0/0", bi0.any_press, bi0.btn_press);
      end
   endtask

   task automatic test_bounce();
      logic v;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         v = (i < 4) ? (i % 2 == 0) : 1'b1;
         step_tick({3'b000, v});
         n_checks++;
         if (bi0.btn_press[0] !== (i == 7)) begin
            n_fail++;
            $display("FAIL bounce_press step %0d: got %b required %b", i, bi0.btn_press[0], (i == 7));
         end
         n_checks++;
         if (bi0.btn_level[0] !== (i == 7)) begin
            n_fail++;
            $display("FAIL bounce_level step %0d: got %b required %b", i, bi0.btn_level[0], (i == 7));
         end
      end
   endtask

   task automatic test_hold_repeat();
      logic exp_rpt;
      do_reset();
      for (int i = 1; i <= 4; i++) step_tick(4'h2);
      n_checks++;
      if (bi0.btn_press !== 4'h2) begin
         n_fail++;
         $display("FAIL hold_press: got %h required 2", bi0.btn_press);
      end
      for (int k = 1; k <= 19; k++) begin
         step_tick(4'h2);
         exp_rpt = (k == 8) || (k == 11) || (k == 14) || (k == 17);
         n_checks++;
         if (bi0.btn_hold[1] !== (k >= 8)) begin
            n_fail++;
            $display("FAIL hold_flag tick %0d: got %b required %b", k, bi0.btn_hold[1], (k >= 8));
         end
         n_checks++;
         if (bi0.btn_repeat[1] !== exp_rpt) begin
            n_fail++;
            $display("FAIL hold_repeat tick %0d: got %b required %b", k, bi0.btn_repeat[1], exp_rpt);
         end
      end
      // Release is accepted on tick 23, exactly where a repeat would otherwise fire.
      for (int r = 1; r <= 4; r++) begin
         step_tick(4'h0);
         n_checks++;
         if (bi0.btn_repeat[1] !== (r == 1)) begin
            n_fail++;
            $display("FAIL release_repeat tick %0d: got %b required %b", 19 + r, bi0.btn_repeat[1], (r == 1));
         end
         n_checks++;
         if (bi0.btn_hold[1] !== (r < 4)) begin
            n_fail++;
            $display("FAIL release_hold tick %0d: got %b required %b", 19 + r, bi0.btn_hold[1], (r < 4));
         end
         n_checks++;
         if (bi0.btn_release[1] !== (r == 4)) begin
            n_fail++;
            $display("FAIL release_pulse tick %0d: got %b required %b", 19 + r, bi0.btn_release[1], (r == 4));
         end
      end
   endtask

   task automatic test_repeat_disabled();
      do_reset();
      for (int i = 1; i <= 4; i++) step_tick(4'h2);
      for (int k = 1; k <= 19; k++) begin
         step_tick(4'h2);
         n_checks++;
         if (bi1.btn_repeat[1] !== (k == 8)) begin
            n_fail++;
            $display("FAIL norpt_repeat tick %0d: got %b required %b", k, bi1.btn_repeat[1], (k == 8));
         end
         n_checks++;
         if (bi1.btn_hold[1] !== (k >= 8)) begin
            n_fail++;
            $display("FAIL norpt_hold tick %0d: got %b required %b", k, bi1.btn_hold[1], (k >= 8));
         end
      end
      for (int r = 1; r <= 4; r++) begin
         step_tick(4'h0);
         n_checks++;
         if (bi1.btn_repeat[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL norpt_release_repeat tick %0d: got %b required 0", 19 + r, bi1.btn_repeat[1]);
         end
         n_checks++;
         if (bi1.btn_hold[1] !== (r < 4) || bi1.btn_release[1] !== (r == 4)) begin
            n_fail++;
            $display("FAIL norpt_release tick %0d: got hold=%b rel=%b required hold=%b rel=%b",
                     19 + r, bi1.btn_hold[1], bi1.btn_release[1], (r < 4), (r == 4));
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [3:0] exp4;
      do_reset();
      tick_en = 1'b1;
      btn_in  = 4'b0101;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk);
         #1;
         exp4 = (c == 6) ? 4'b0101 : 4'b0000;
         n_checks++;
         if (bi0.btn_press !== exp4) begin
            n_fail++;
            $display("FAIL simul_press clk %0d: got %h required %h", c, bi0.btn_press, exp4);
         end
         n_checks++;
         if (bi0.any_press !== (c == 6)) begin
            n_fail++;
            $display("FAIL simul_any clk %0d: got %b required %b", c, bi0.any_press, (c == 6));
         end
      end
      // Three-clock glitch on ch3 reaches only three consecutive mismatching samples.
      @(negedge clk);
      btn_in = 4'b1101;
      repeat (3) @(negedge clk);
      btn_in = 4'b0101;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (bi0.btn_level !== 4'b0101 || bi0.btn_press[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_ch3 clk %0d: got level=%h press3=%b required level=5 press3=0",
                     c, bi0.btn_level, bi0.btn_press[3]);
         end
      end
      @(negedge clk);
      tick_en = 1'b0;
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      for (int i = 1; i <= 14; i++) step_tick(4'h2);
      n_checks++;
      if (bi0.btn_hold[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL midhold_pre: got hold=%b required 1", bi0.btn_hold[1]);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (bi0.btn_hold[1] !== 1'b0 || bi0.btn_level[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL midhold_async: got hold=%b level=%b required 0/0", bi0.btn_hold[1], bi0.btn_level[1]);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step_tick(4'h2);
         n_checks++;
         if (bi0.btn_press[1] !== (i == 4)) begin
            n_fail++;
            $display("FAIL midhold_repress tick %0d: got %b required %b", i, bi0.btn_press[1], (i == 4));
         end
      end
      for (int k = 1; k <= 9; k++) begin
         step_tick(4'h2);
         n_checks++;
         if (bi0.btn_hold[1] !== (k >= 8)) begin
            n_fail++;
            $display("FAIL midhold_retime tick %0d: got %b required %b", k, bi0.btn_hold[1], (k >= 8));
         end
      end
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_hold_repeat();
      test_repeat_disabled();
      test_simultaneous();
      test_reset_mid_hold();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
